// File: rtl/rv_pkg.sv
// Shared integer-pipeline definitions: register/word widths, load funct3 codes
// and the writeback queue entry layout.
package rv_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [2:0]            funct3;
      logic [1:0]            addr_lo;
      logic [XLEN-1:0]       rdata;
   } load_entry_t;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_ALU_ONLY,
      WB_DRAIN,
      WB_STALL
   } wb_sel_t;

endpackage

// File: rtl/load_align_ext.sv
// Selects the addressed byte/halfword of an aligned load word and extends it.
// Purely combinational so it can be shared with the forwarding path.
module load_align_ext
   import rv_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] ext_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_lo)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      // halfwords are always naturally aligned, so only addr_lo[1] matters
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      ext_data = rdata;
      case (funct3)
         F3_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  ext_data = {24'h0, byte_sel};
         F3_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  ext_data = {16'h0, half_sel};
         default: ext_data = rdata;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Owns the register-file write port: ALU results win by default, load responses
// wait in a 2-entry queue, and a starvation counter stalls the ALU when needed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | queue empty, no ALU result: no write
// ALU_ONLY | ALU result written, queued load (if any) keeps waiting
// DRAIN    | no ALU result, queue head popped and written
// STALL    | starvation limit reached: ALU held, queue head popped
module writeback_unit
   import rv_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_result,
   output logic                  alu_stall,
   input  logic                  mem_rsp_valid,
   output logic                  mem_rsp_ready,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [2:0]            mem_funct3,
   input  logic [1:0]            mem_addr_lo,
   input  logic [XLEN-1:0]       mem_rdata,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_rd,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  busy
);

   load_entry_t           q [2];
   logic                  wptr;
   logic                  rptr;
   logic [1:0]            count;
   logic [3:0]            wait_cnt;
   logic                  rf_we_q;
   logic [REG_ADDR_W-1:0] rf_rd_q;
   logic [XLEN-1:0]       rf_wdata_q;

   load_entry_t           head;
   logic [XLEN-1:0]       head_ext;
   logic                  full;
   logic                  empty;
   logic                  starved;
   logic                  push;
   logic                  pop;
   wb_sel_t               sel;

   assign head    = q[rptr];
   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign starved = (wait_cnt >= 4'(STARVE_LIMIT));

   assign alu_stall     = starved & ~reset;
   assign mem_rsp_ready = ~full & ~reset;
   assign push          = mem_rsp_valid & mem_rsp_ready;

   always_comb begin
      sel = WB_IDLE;
      if (starved)        sel = WB_STALL;
      else if (alu_valid) sel = WB_ALU_ONLY;
      else if (!empty)    sel = WB_DRAIN;
   end

   assign pop = ((sel == WB_STALL) || (sel == WB_DRAIN)) && !empty;

   load_align_ext u_ext (
      .funct3   (head.funct3),
      .addr_lo  (head.addr_lo),
      .rdata    (head.rdata),
      .ext_data (head_ext)
   );

   always_ff @(posedge clk) begin
      if (push) q[wptr] <= '{rd: mem_rd, funct3: mem_funct3,
                             addr_lo: mem_addr_lo, rdata: mem_rdata};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr       <= 1'b0;
         rptr       <= 1'b0;
         count      <= 2'd0;
         wait_cnt   <= 4'd0;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_wdata_q <= '0;
      end else begin
         if (push) wptr <= ~wptr;
         if (pop)  rptr <= ~rptr;
         count <= count + {1'b0, push} - {1'b0, pop};

         if (empty || pop)          wait_cnt <= 4'd0;
         else if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;

         rf_we_q <= 1'b0;
         case (sel)
            WB_ALU_ONLY: begin
               rf_we_q    <= (alu_rd != '0);
               rf_rd_q    <= alu_rd;
               rf_wdata_q <= alu_result;
            end
            WB_DRAIN, WB_STALL: begin
               if (!empty) begin
                  rf_we_q    <= (head.rd != '0);
                  rf_rd_q    <= head.rd;
                  rf_wdata_q <= head_ext;
               end
            end
            default: rf_we_q <= 1'b0;
         endcase
      end
   end

   // outputs read as zero throughout the reset cycle, not just after it
   assign rf_we    = rf_we_q & ~reset;
   assign rf_rd    = reset ? '0 : rf_rd_q;
   assign rf_wdata = reset ? '0 : rf_wdata_q;
   assign busy     = ~reset & (~empty | rf_we_q);

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: expected writes go into a scoreboard queue,
// a forked monitor compares every rf_we pulse against the queue head.
module tb_writeback_unit;
   import rv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_result;
   logic        alu_stall;
   logic        mem_rsp_valid;
   logic        mem_rsp_ready;
   logic [4:0]  mem_rd;
   logic [2:0]  mem_funct3;
   logic [1:0]  mem_addr_lo;
   logic [31:0] mem_rdata;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic        busy;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q [$];
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;

   writeback_unit #(.STARVE_LIMIT(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .alu_valid     (alu_valid),
      .alu_rd        (alu_rd),
      .alu_result    (alu_result),
      .alu_stall     (alu_stall),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_ready (mem_rsp_ready),
      .mem_rd        (mem_rd),
      .mem_funct3    (mem_funct3),
      .mem_addr_lo   (mem_addr_lo),
      .mem_rdata     (mem_rdata),
      .rf_we         (rf_we),
      .rf_rd         (rf_rd),
      .rf_wdata      (rf_wdata),
      .busy          (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] res);
      alu_valid  = v;
      alu_rd     = rd;
      alu_result = res;
   endtask

   task automatic set_mem(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] lo, input logic [31:0] data);
      mem_rsp_valid = v;
      mem_rd        = rd;
      mem_funct3    = f3;
      mem_addr_lo   = lo;
      mem_rdata     = data;
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
      exp_q.push_back('{rd: rd, d: d});
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", rf_rd, rf_wdata);
            end else begin
               e = exp_q.pop_front();
               if (rf_rd !== e.rd || rf_wdata !== e.d) begin
                  errors++;
                  $display("FAIL write: got rd=%0d data=%h, expected rd=%0d data=%h",
                           rf_rd, rf_wdata, e.rd, e.d);
               end
            end
         end
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         step();
         n++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
      step();
   endtask

   logic [2:0]  v_f3  [8] = '{F3_LB, F3_LHU, F3_LH, F3_LBU, F3_LW, 3'b011, F3_LB, F3_LH};
   logic [1:0]  v_lo  [8] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd3};
   logic [31:0] v_dat [8] = '{32'h80112233, 32'h80112233, 32'h0000F00D, 32'h80112233,
                              32'h80112233, 32'h12345678, 32'h0000007F, 32'hABCD0000};
   logic [31:0] v_exp [8] = '{32'hFFFFFF80, 32'h00008011, 32'hFFFFF00D, 32'h00000022,
                              32'h80112233, 32'h12345678, 32'h0000007F, 32'hFFFFABCD};

   initial begin
      fork
         monitor();
      join_none

      reset = 1'b1;
      set_alu(1'b0, 5'd0, 32'h0);
      set_mem(1'b0, 5'd0, 3'b000, 2'd0, 32'h0);
      step();
      step();
      chk("reset_rf_we", 32'(rf_we), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ready", 32'(mem_rsp_ready), 32'd0);
      chk("reset_stall", 32'(alu_stall), 32'd0);
      chk("reset_wdata", rf_wdata, 32'd0);
      reset = 1'b0;
      step();
      chk("ready_after_reset", 32'(mem_rsp_ready), 32'd1);

      // ALU only
      set_alu(1'b1, 5'd5, 32'hDEADBEEF);
      expect_wr(5'd5, 32'hDEADBEEF);
      step();
      set_alu(1'b0, 5'd0, 32'h0);
      chk("alu_busy", 32'(busy), 32'd1);
      drain("alu_drain");

      // load extension, one at a time, checking the 2-cycle latency
      for (int i = 0; i < 8; i++) begin
         set_mem(1'b1, 5'(i + 1), v_f3[i], v_lo[i], v_dat[i]);
         expect_wr(5'(i + 1), v_exp[i]);
         step();
         set_mem(1'b0, 5'd0, 3'b000, 2'd0, 32'h0);
         chk("load_no_bypass", 32'(rf_we), 32'd0);
         step();
         chk("load_latency", 32'(rf_we), 32'd1);
         step();
      end
      drain("ext_drain");

      // queue full plus starvation: L1 accepted at edge A, stall during cycle A+5
      set_alu(1'b1, 5'd7, 32'hA0000010);
      set_mem(1'b1, 5'd11, F3_LW, 2'd0, 32'h11111111);
      expect_wr(5'd7, 32'hA0000010);
      step();
      chk("q1_ready", 32'(mem_rsp_ready), 32'd1);
      set_alu(1'b1, 5'd7, 32'hA0000011);
      set_mem(1'b1, 5'd12, F3_LBU, 2'd1, 32'h0000AB00);
      expect_wr(5'd7, 32'hA0000011);
      step();
      chk("full_ready", 32'(mem_rsp_ready), 32'd0);
      set_mem(1'b1, 5'd13, F3_LH, 2'd2, 32'hFFFE0000);
      for (int k = 2; k < 5; k++) begin
         chk("no_stall_early", 32'(alu_stall), 32'd0);
         set_alu(1'b1, 5'd7, 32'hA0000010 + 32'(k));
         expect_wr(5'd7, 32'hA0000010 + 32'(k));
         step();
      end
      chk("stall_raised", 32'(alu_stall), 32'd1);
      chk("stall_full_ready", 32'(mem_rsp_ready), 32'd0);
      set_alu(1'b1, 5'd7, 32'hA0000015);
      expect_wr(5'd11, 32'h11111111);
      step();
      chk("stall_cleared", 32'(alu_stall), 32'd0);
      chk("ready_after_pop", 32'(mem_rsp_ready), 32'd1);
      expect_wr(5'd7, 32'hA0000015);
      step();
      chk("refull_ready", 32'(mem_rsp_ready), 32'd0);
      set_alu(1'b0, 5'd0, 32'h0);
      set_mem(1'b0, 5'd0, 3'b000, 2'd0, 32'h0);
      expect_wr(5'd12, 32'h000000AB);
      expect_wr(5'd13, 32'hFFFFFFFE);
      drain("full_drain");

      // rd=0 winners are consumed silently
      set_alu(1'b1, 5'd0, 32'h12345678);
      step();
      set_alu(1'b0, 5'd0, 32'h0);
      chk("rd0_alu_we", 32'(rf_we), 32'd0);
      set_mem(1'b1, 5'd0, F3_LW, 2'd0, 32'hCAFEF00D);
      step();
      set_mem(1'b0, 5'd0, 3'b000, 2'd0, 32'h0);
      chk("rd0_load_busy", 32'(busy), 32'd1);
      step();
      chk("rd0_load_we", 32'(rf_we), 32'd0);
      chk("rd0_popped", 32'(busy), 32'd0);

      // reset with two queued entries (ALU rd=0 keeps them from draining)
      set_alu(1'b1, 5'd0, 32'h0);
      set_mem(1'b1, 5'd9, F3_LW, 2'd0, 32'h99999999);
      step();
      set_mem(1'b1, 5'd10, F3_LW, 2'd0, 32'hAAAAAAAA);
      step();
      set_mem(1'b0, 5'd0, 3'b000, 2'd0, 32'h0);
      chk("two_queued_ready", 32'(mem_rsp_ready), 32'd0);
      chk("two_queued_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_ready", 32'(mem_rsp_ready), 32'd0);
      step();
      set_alu(1'b0, 5'd0, 32'h0);
      reset = 1'b0;
      chk("post_reset_we", 32'(rf_we), 32'd0);
      step();
      chk("post_reset_ready", 32'(mem_rsp_ready), 32'd1);
      chk("post_reset_busy", 32'(busy), 32'd0);
      repeat (4) step();
      chk("post_reset_idle", 32'(busy), 32'd0);
      drain("final_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage that owns the single write port of the integer register file. It merges single-cycle ALU results with variable-latency load responses from the data-memory interface, sign/zero-extends load data, and drives registered `rf_we`/`rf_rd`/`rf_wdata` into the register file. Load responses are buffered in a 2-entry queue; ALU results have priority, bounded by a starvation limiter that stalls the ALU.

## Interface

- `STARVE_LIMIT`, 4: cycles a queued load may lose arbitration before `alu_stall` is raised; legal range 1–15.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `alu_valid`  in  1  ALU result present this cycle; ignored while `alu_stall`=1, and upstream holds it.
- `alu_rd`  in  5  ALU destination register.
- `alu_result`  in  32  ALU result.
- `alu_stall`  out  1  upstream must hold the ALU result this cycle.
- `mem_rsp_valid`  in  1  load response valid.
- `mem_rsp_ready`  out  1  queue can accept; handshake is `valid && ready`.
- `mem_rd`  in  5  load destination register.
- `mem_funct3`  in  3  load type.
- `mem_addr_lo`  in  2  byte offset of load address.
- `mem_rdata`  in  32  raw aligned memory word.
- `rf_we`  out  1  register-file write enable.
- `rf_rd`  out  5  register-file write address.
- `rf_wdata`  out  32  register-file write data.
- `busy`  out  1  queue non-empty or `rf_we` high.

## Operation

- Queue: 2 entries {rd, funct3, addr_lo, rdata}. The queue stores raw data; extension is applied at drain. Wrap-around uses 1-bit read and write pointers plus a 2-bit count.
- `mem_rsp_ready` = !full && !reset. It depends only on state, not on a same-cycle pop. Push and pop in the same cycle are legal when count is 1.
- Arbitration each cycle:
  - `alu_stall`=1: pop the queue head.
  - Otherwise, if `alu_valid`: take the ALU result.
  - Otherwise, if the queue is non-empty: pop the head.
  - Otherwise: idle.
- A winner with rd=0 is consumed (popped or taken) but produces `rf_we`=0.
- Starvation counter `wait_cnt` (4 bits):
  - Clears when the queue is empty or on a pop.
  - Otherwise increments, saturating at 15.
  - `alu_stall` = (`wait_cnt` >= `STARVE_LIMIT`).
- Extension uses the head's funct3 and addr_lo:
  - 000 LB: byte[addr_lo], sign-extended.
  - 100 LBU: byte[addr_lo], zero-extended.
  - 001 LH: half[addr_lo[1]], sign-extended.
  - 101 LHU: half[addr_lo[1]], zero-extended.
  - 010 LW and any other code: word passed unchanged.
  - addr_lo[0] is ignored for halfwords.
- States are implicit: IDLE (empty, no writes), ALU_ONLY, DRAIN (pop), STALL (`alu_stall` high, pop). Transitions follow the arbitration rules above.

## Timing

- Reset (synchronous): `rf_we`=0, `rf_rd`=0, `rf_wdata`=0, `alu_stall`=0, `busy`=0, `mem_rsp_ready`=0 during the reset cycle. Queue is emptied and `wait_cnt`=0.
- Reset mid-operation discards queued loads. No write is issued in the cycle after reset.
- ALU latency: `alu_valid` sampled at edge N → `rf_we`/`rf_rd`/`rf_wdata` valid after edge N, held for one cycle.
- Load latency with an empty queue and no ALU competition: handshake at edge N → entry queued → popped at edge N+1 → `rf_we` valid after edge N+1. Minimum is 2 cycles; there is no bypass.
- Throughput: one register-file write per cycle maximum.
- All outputs are registered or decoded from registers only. There are no combinational input-to-output paths.

## Structure

- Shared package `rv_pkg`: load funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`, and the `REG_ADDR_W`=5 and `XLEN`=32 constants.
- Sub-module `load_align_ext`: purely combinational; inputs funct3, addr_lo, rdata; output 32-bit extended data. It is reused later by the forwarding unit.
- Queue, arbiter and counter stay in `writeback_unit`.

## Test plan

- ALU only: `alu_valid`=1, rd=5, result 0xDEADBEEF → next cycle `rf_we`=1, `rf_rd`=5, `rf_wdata`=0xDEADBEEF.
- Load extension: LB addr_lo=3, rdata 0x80112233 → 0xFFFFFF80. LHU addr_lo=2, same rdata → 0x00008011. LH addr_lo=0, rdata 0x0000F00D → 0xFFFFF00D.
- Queue full: two loads accepted while ALU continuously valid → `mem_rsp_ready`=0. A third response is held by the source and not lost. All three are eventually written, in order.
- Starvation with `STARVE_LIMIT`=4: load accepted at edge 0, ALU valid every cycle → `alu_stall`=1 during cycle 5, load written after edge 5, and the held ALU result is written the following cycle.
- rd=0: ALU rd=0 and load rd=0 → `rf_we` stays 0 and the queue entry is popped (`busy` falls).
- Reset mid-operation: reset asserted with 2 queued entries → after reset `busy`=0, no `rf_we` pulses, `mem_rsp_ready`=1 the cycle after reset deasserts.
